rr_pkt_arbiter: RTL and testbench
=================================

RR_PKT_ARBITER -- requirements
Module: rr_pkt_arbiter

Interface
REQ-001 SHALL have parameter RR_WIDTH, default 8: number of requesters (ingress ports).
REQ-002 SHALL have parameter RR_WIDTH_L2, default $clog2(RR_WIDTH): width of binary grant index and priority pointer.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 1023: watchdog limit in cycles (used only with REQ-030).
REQ-004 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port req, input, RR_WIDTH: per-requester packet request, level.
REQ-007 SHALL have port eop, input, 1: end-of-packet from current grantee, valid only while gnt_valid=1.
REQ-008 SHALL have port gnt, output, RR_WIDTH: registered one-hot grant.
REQ-009 SHALL have port gnt_bin, output, RR_WIDTH_L2: registered binary index of gnt.
REQ-010 SHALL have port gnt_valid, output, 1: high while a grant is held.
REQ-011 SHALL have port arb_timeout, output, 1: one-cycle pulse on forced release.

Function
REQ-012 SHALL implement two states: IDLE (no grant) and BUSY (grant held).
REQ-013 IDLE with req=0 SHALL stay IDLE.
REQ-014 IDLE with req!=0 SHALL register a grant on that edge and enter BUSY: one-cycle latency, req to gnt.
REQ-015 Grant selection SHALL be the first set req bit at or after priority pointer ptr, searching upward and wrapping from RR_WIDTH-1 to 0.
REQ-016 In BUSY, gnt and gnt_bin SHALL hold constant until release, whatever req does, including deassertion of the grantee's req.
REQ-017 Release SHALL occur on a cycle in BUSY with eop=1; eop in IDLE SHALL be ignored.
REQ-018 On release, ptr SHALL be set to (gnt_bin+1) mod RR_WIDTH, wrapping RR_WIDTH-1 to 0.
REQ-019 On release with req!=0 in the same cycle, the next grant SHALL be selected from req using the updated ptr and registered on that edge: back-to-back, no dead cycle, state stays BUSY.
REQ-020 On release with req=0, the block SHALL enter IDLE and clear gnt and gnt_valid.
REQ-021 The releasing grantee SHALL be re-granted back-to-back only if it is the sole requester, because it has lowest priority after the ptr update.
REQ-022 gnt SHALL always be zero or one-hot; gnt_bin SHALL equal the index of gnt; gnt_valid SHALL equal |gnt.
REQ-023 ptr SHALL change only on release; a grant from IDLE SHALL use the current ptr.
REQ-024 Priority search SHALL be combinational within the cycle; all outputs SHALL be registered.

Reset
REQ-025 rst=1 SHALL, at the next edge, set state IDLE, gnt=0, gnt_bin=0, gnt_valid=0, ptr=0, arb_timeout=0, and clear the watchdog counter.
REQ-026 rst asserted in BUSY mid-packet SHALL drop the grant at that edge with no ptr update; the first grant after reset SHALL use ptr=0.
REQ-027 req and eop SHALL be ignored on any cycle with rst=1.

Configuration
REQ-028 The timeout watchdog SHALL be compiled in only when macro RR_ARB_TIMEOUT_EN is defined.
REQ-029 Without RR_ARB_TIMEOUT_EN, arb_timeout SHALL be tied 0, no counter logic SHALL exist, and release SHALL occur only by eop.
REQ-030 With RR_ARB_TIMEOUT_EN, a counter SHALL clear on entry to BUSY and on every grant change, and increment each BUSY cycle without eop.
REQ-031 With RR_ARB_TIMEOUT_EN, when the counter reaches TIMEOUT_CYC, the block SHALL perform a release exactly as for eop (REQ-018..020) and pulse arb_timeout for one cycle.
REQ-032 With RR_ARB_TIMEOUT_EN, eop and timeout in the same cycle SHALL be treated as a normal eop release, with arb_timeout=0.

Structure
REQ-033 State encoding and the default TIMEOUT_CYC constant SHALL reside in the shared switch package.
REQ-034 The priority search SHALL instantiate existing sub-module rnd_rb_ppe (ports rr_vec_in=req, rr_priority=next-ptr, rr_vec_out, rr_bin_out); no other sub-modules.

Verification
REQ-035 The bench SHALL check: after reset, req=8'b0000_0001 -> gnt=8'h01, gnt_bin=0, gnt_valid=1 one cycle later.
REQ-036 The bench SHALL check: req=8'hFF with eop every 3rd cycle -> grants cycle 0,1,2,...,7,0 back-to-back with no idle cycle.
REQ-037 The bench SHALL check: grantee 7 holds, req=8'h81, then eop -> ptr wraps to 0, next gnt=8'h01.
REQ-038 The bench SHALL check: grant to 3, then req[3] drops with no eop for 20 cycles -> gnt=8'h08 held; rst=1 mid-packet -> gnt=0 and ptr=0 next cycle.
REQ-039 The bench SHALL check, with RR_ARB_TIMEOUT_EN and TIMEOUT_CYC=16: no eop -> arb_timeout pulses once on the 16th BUSY cycle and the grant advances; without the macro, the grant is held indefinitely.

Source files
------------

// File: rtl/rr_pkt_arbiter_pkg.sv
// rtl/rr_pkt_arbiter_pkg.sv - shared state encoding and defaults for the packet arbiter
package rr_pkt_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_t;

  localparam int RR_TIMEOUT_CYC_DEF = 1023;

endpackage

// File: rtl/rnd_rb_ppe.sv
// rtl/rnd_rb_ppe.sv - programmable-priority encoder: first set bit at or after rr_priority, wrapping
module rnd_rb_ppe #(
  parameter int RR_WIDTH    = 8,
  parameter int RR_WIDTH_L2 = $clog2(RR_WIDTH)
) (
  input  logic [RR_WIDTH-1:0]    rr_vec_in,
  input  logic [RR_WIDTH_L2-1:0] rr_priority,
  output logic [RR_WIDTH-1:0]    rr_vec_out,
  output logic [RR_WIDTH_L2-1:0] rr_bin_out
);

  logic found;

  // Walk the request vector starting at the priority slot; keep only the first hit.
  always_comb begin
    rr_vec_out = '0;
    rr_bin_out = '0;
    found      = 1'b0;
    for (int i = 0; i < RR_WIDTH; i++) begin
      if (!found && rr_vec_in[(int'(rr_priority) + i) % RR_WIDTH]) begin
        found = 1'b1;
        rr_vec_out[(int'(rr_priority) + i) % RR_WIDTH] = 1'b1;
        rr_bin_out = RR_WIDTH_L2'((int'(rr_priority) + i) % RR_WIDTH);
      end
    end
  end

endmodule

// File: rtl/rr_pkt_arbiter.sv
// rtl/rr_pkt_arbiter.sv - round-robin packet arbiter; optional watchdog under RR_ARB_TIMEOUT_EN
module rr_pkt_arbiter
  import rr_pkt_arbiter_pkg::*;
#(
  parameter int RR_WIDTH    = 8,
  parameter int RR_WIDTH_L2 = $clog2(RR_WIDTH),
  parameter int TIMEOUT_CYC = RR_TIMEOUT_CYC_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [RR_WIDTH-1:0]    req,
  input  logic                   eop,
  output logic [RR_WIDTH-1:0]    gnt,
  output logic [RR_WIDTH_L2-1:0] gnt_bin,
  output logic                   gnt_valid,
  output logic                   arb_timeout
);

  arb_state_t             state_q, state_d;
  logic [RR_WIDTH_L2-1:0] ptr_q;
  logic [RR_WIDTH_L2-1:0] next_ptr;
  logic [RR_WIDTH-1:0]    ppe_vec;
  logic [RR_WIDTH_L2-1:0] ppe_bin;
  logic                   any_req;
  logic                   force_release;
  logic                   release_now;
  logic                   load_grant;

  assign any_req     = |req;
  assign release_now = (state_q == ST_BUSY) && (eop || force_release);
  assign load_grant  = any_req && ((state_q == ST_IDLE) || release_now);

  // The releasing grantee drops to lowest priority, so the search for the
  // back-to-back grant already starts one past it.
  always_comb begin
    next_ptr = ptr_q;
    if (release_now) begin
      if (gnt_bin == RR_WIDTH_L2'(RR_WIDTH - 1)) begin
        next_ptr = '0;
      end else begin
        next_ptr = gnt_bin + 1'b1;
      end
    end
  end

  rnd_rb_ppe #(
    .RR_WIDTH    (RR_WIDTH),
    .RR_WIDTH_L2 (RR_WIDTH_L2)
  ) u_ppe (
    .rr_vec_in   (req),
    .rr_priority (next_ptr),
    .rr_vec_out  (ppe_vec),
    .rr_bin_out  (ppe_bin)
  );

  // Next-state: leave IDLE on any request, leave BUSY only on a release with nobody waiting.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (any_req) state_d = ST_BUSY;
      ST_BUSY: if (release_now && !any_req) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, pointer and registered grant outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      gnt       <= '0;
      gnt_bin   <= '0;
      gnt_valid <= 1'b0;
    end else begin
      state_q <= state_d;
      if (release_now) ptr_q <= next_ptr;
      if (load_grant) begin
        gnt       <= ppe_vec;
        gnt_bin   <= ppe_bin;
        gnt_valid <= 1'b1;
      end else if (release_now) begin
        gnt       <= '0;
        gnt_bin   <= '0;
        gnt_valid <= 1'b0;
      end
    end
  end

`ifdef RR_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] to_cnt;

  // Counter holds the number of completed cycles of the current grant; eop wins over timeout.
  assign force_release = (state_q == ST_BUSY) && !eop && (to_cnt == TO_LAST);

  // Watchdog counter and one-cycle timeout pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt      <= '0;
      arb_timeout <= 1'b0;
    end else begin
      arb_timeout <= force_release;
      if (load_grant || release_now) begin
        to_cnt <= '0;
      end else if (state_q == ST_BUSY && !eop) begin
        to_cnt <= to_cnt + 1'b1;
      end
    end
  end
`else
  localparam int UNUSED_TIMEOUT_CYC = TIMEOUT_CYC;

  assign force_release = 1'b0;
  assign arb_timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_rr_pkt_arbiter.sv
// tb/tb_rr_pkt_arbiter.sv - self-checking bench for rr_pkt_arbiter (vectors, sequences, random vs model)
module tb_rr_pkt_arbiter;

`ifdef RR_ARB_TIMEOUT_EN
  localparam int TO     = 16;
  localparam bit TO_EN  = 1'b1;
`else
  localparam int TO     = 1023;
  localparam bit TO_EN  = 1'b0;
`endif
  localparam int W = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = '0;
  logic       eop = 1'b0;
  logic [7:0] gnt;
  logic [2:0] gnt_bin;
  logic       gnt_valid;
  logic       arb_timeout;

  int n_cmp = 0;
  int n_bad = 0;

  int m_own  = -1;
  int m_ptr  = 0;
  int m_held = 0;
  int m_tmo  = 0;

  rr_pkt_arbiter #(
    .RR_WIDTH    (W),
    .RR_WIDTH_L2 (3),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .eop         (eop),
    .gnt         (gnt),
    .gnt_bin     (gnt_bin),
    .gnt_valid   (gnt_valid),
    .arb_timeout (arb_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [7:0] r, input int p);
    for (int k = 0; k < W; k++) begin
      if (r[(p + k) % W]) return (p + k) % W;
    end
    return -1;
  endfunction

  // One clock: drive inputs, advance the reference model at the edge, compare #1 later.
  task automatic step(input logic r, input logic [7:0] rq, input logic e);
    int rel;
    rst = r;
    req = rq;
    eop = e;
    @(posedge clk);
    m_tmo = 0;
    if (r) begin
      m_own = -1; m_ptr = 0; m_held = 0;
    end else if (m_own < 0) begin
      if (rq != 0) begin
        m_own = pick(rq, m_ptr); m_held = 1;
      end
    end else begin
      rel = e ? 1 : 0;
      if (TO_EN && !e && m_held == TO) begin
        rel = 1; m_tmo = 1;
      end
      if (rel != 0) begin
        m_ptr = (m_own + 1) % W;
        if (rq != 0) begin
          m_own = pick(rq, m_ptr); m_held = 1;
        end else begin
          m_own = -1; m_held = 0;
        end
      end else begin
        m_held++;
      end
    end
    #1;
    chk("model_gnt", int'(gnt), (m_own < 0) ? 0 : (1 << m_own));
    chk("model_gnt_bin", int'(gnt_bin), (m_own < 0) ? 0 : m_own);
    chk("model_gnt_valid", int'(gnt_valid), (m_own < 0) ? 0 : 1);
    chk("model_arb_timeout", int'(arb_timeout), m_tmo);
  endtask

  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic       eop;
    logic [7:0] exp_gnt;
  } vec_t;

  vec_t tbl[12];

  initial begin
    tbl[0]  = '{1'b1, 8'h00, 1'b0, 8'h00};
    tbl[1]  = '{1'b0, 8'h01, 1'b0, 8'h01};
    tbl[2]  = '{1'b0, 8'h01, 1'b0, 8'h01};
    tbl[3]  = '{1'b0, 8'h81, 1'b1, 8'h80};
    tbl[4]  = '{1'b0, 8'h81, 1'b0, 8'h80};
    tbl[5]  = '{1'b0, 8'h81, 1'b1, 8'h01};
    tbl[6]  = '{1'b0, 8'h00, 1'b1, 8'h00};
    tbl[7]  = '{1'b0, 8'h00, 1'b1, 8'h00};
    tbl[8]  = '{1'b0, 8'h09, 1'b0, 8'h08};
    tbl[9]  = '{1'b0, 8'h00, 1'b0, 8'h08};
    tbl[10] = '{1'b0, 8'h00, 1'b0, 8'h08};
    tbl[11] = '{1'b1, 8'hFF, 1'b1, 8'h00};

    // Vector table: reset state, first grant, wrap of the pointer, eop in IDLE.
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].rst, tbl[i].req, tbl[i].eop);
      chk($sformatf("vec%0d_gnt", i), int'(gnt), int'(tbl[i].exp_gnt));
      chk($sformatf("vec%0d_valid", i), int'(gnt_valid), (tbl[i].exp_gnt != 0) ? 1 : 0);
    end

    // All requesting, eop on every third held cycle: 0..7,0 with no idle cycle.
    step(1'b1, 8'h00, 1'b0);
    step(1'b0, 8'hFF, 1'b0);
    for (int g = 0; g < 9; g++) begin
      for (int c = 0; c < 3; c++) begin
        chk($sformatf("rr_seq%0d_bin", g), int'(gnt_bin), g % W);
        chk($sformatf("rr_seq%0d_valid", g), int'(gnt_valid), 1);
        step(1'b0, 8'hFF, (c == 2) ? 1'b1 : 1'b0);
      end
    end

    // Grantee 3 drops its request: grant must persist; reset mid-packet clears it and the pointer.
    step(1'b1, 8'h00, 1'b0);
    step(1'b0, 8'h08, 1'b0);
    chk("hold3_first", int'(gnt), 8'h08);
    for (int c = 0; c < 20; c++) begin
      step(1'b0, 8'h00, 1'b0);
`ifndef RR_ARB_TIMEOUT_EN
      chk($sformatf("hold3_c%0d", c), int'(gnt), 8'h08);
`endif
    end
    step(1'b1, 8'hFF, 1'b1);
    chk("rst_mid_gnt", int'(gnt), 8'h00);
    chk("rst_mid_valid", int'(gnt_valid), 0);
    step(1'b0, 8'hFF, 1'b0);
    chk("post_rst_ptr0", int'(gnt), 8'h01);

    // Watchdog behaviour with no eop at all.
    step(1'b1, 8'h00, 1'b0);
    step(1'b0, 8'h06, 1'b0);
    chk("wd_first", int'(gnt), 8'h02);
`ifdef RR_ARB_TIMEOUT_EN
    for (int c = 0; c < TO - 1; c++) begin
      step(1'b0, 8'h06, 1'b0);
      chk($sformatf("wd_hold%0d", c), int'(gnt), 8'h02);
      chk($sformatf("wd_quiet%0d", c), int'(arb_timeout), 0);
    end
    step(1'b0, 8'h06, 1'b0);
    chk("wd_advance", int'(gnt), 8'h04);
    chk("wd_pulse", int'(arb_timeout), 1);
    step(1'b0, 8'h06, 1'b0);
    chk("wd_pulse_end", int'(arb_timeout), 0);
`else
    for (int c = 0; c < 40; c++) begin
      step(1'b0, 8'h06, 1'b0);
      chk($sformatf("nowd_hold%0d", c), int'(gnt), 8'h02);
      chk($sformatf("nowd_tmo%0d", c), int'(arb_timeout), 0);
    end
`endif

    // Random traffic against the reference model.
    step(1'b1, 8'h00, 1'b0);
    for (int n = 0; n < 600; n++) begin
      logic       r;
      logic [7:0] rq;
      logic       e;
      r  = ($urandom_range(0, 59) == 0);
      rq = 8'($urandom);
      if ($urandom_range(0, 3) == 0) rq = 8'h00;
      e  = ($urandom_range(0, 2) == 0);
      step(r, rq, e);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
